// File: rtl/i2s_pkg.sv
// Shared types for the I2S source arbiter: modes, source ids, FSM states and
// the default-width stereo sample, plus the per-mode source selection rule.
package i2s_pkg;

  localparam int SAMPLE_W_DEF = 16;

  typedef enum logic [1:0] {
    MODE_MUTE = 2'b00,
    MODE_A    = 2'b01,
    MODE_B    = 2'b10,
    MODE_BPRI = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'b00,
    SRC_A    = 2'b01,
    SRC_B    = 2'b10
  } src_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ARB  = 2'b01,
    S_PUSH = 2'b10
  } state_e;

  typedef struct packed {
    logic [SAMPLE_W_DEF-1:0] left;
    logic [SAMPLE_W_DEF-1:0] right;
  } stereo_t;

  // B-priority falls back to A whenever B has nothing to offer this cycle.
  function automatic src_e select_src(input mode_e mode, input logic b_valid);
    case (mode)
      MODE_A:    return SRC_A;
      MODE_B:    return SRC_B;
      MODE_BPRI: return b_valid ? SRC_B : SRC_A;
      default:   return SRC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mod_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module mod_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_count <= '0;
    end else if (i_inc && (o_count != {CNT_W{1'b1}})) begin
      o_count <= o_count + 1'b1;
    end
  end

endmodule

// File: rtl/mod_i2s_src_arb.sv
// Per-frame sample feeder for the I2S transmitter: picks source A or B by mode,
// handshakes one stereo pair, and reports underruns and frame overruns.
module mod_i2s_src_arb
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W         = SAMPLE_W_DEF,
  parameter int TIMEOUT          = 64,
  parameter bit HOLD_ON_UNDERRUN = 1'b1,
  parameter int CNT_W            = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_frame_req,
  input  logic [1:0]          i_mode,
  input  logic                i_a_valid,
  input  logic [SAMPLE_W-1:0] i_a_left,
  input  logic [SAMPLE_W-1:0] i_a_right,
  output logic                o_a_ready,
  input  logic                i_b_valid,
  input  logic [SAMPLE_W-1:0] i_b_left,
  input  logic [SAMPLE_W-1:0] i_b_right,
  output logic                o_b_ready,
  output logic [SAMPLE_W-1:0] o_left,
  output logic [SAMPLE_W-1:0] o_right,
  output logic                o_sample_valid,
  output logic [1:0]          o_active_src,
  output logic                o_underrun,
  output logic [CNT_W-1:0]    o_underrun_cnt,
  output logic [CNT_W-1:0]    o_overrun_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } sample_t;

  state_e           state_reg, state_next;
  mode_e            mode_reg;
  logic             frame_req_reg;
  logic             frame_edge;
  logic [TMR_W-1:0] timer_reg;
  sample_t          latch_reg;
  src_e             latch_src_reg;
  src_e             sel_src;
  logic             take;
  logic             timeout;
  logic             overrun_inc;

  assign frame_edge  = i_frame_req & ~frame_req_reg;
  assign overrun_inc = frame_edge && (state_reg != S_IDLE);

  always_comb begin
    sel_src    = select_src(mode_reg, i_b_valid);
    o_a_ready  = 1'b0;
    o_b_ready  = 1'b0;
    if (state_reg == S_ARB) begin
      o_a_ready = (sel_src == SRC_A) && i_a_valid;
      o_b_ready = (sel_src == SRC_B) && i_b_valid;
    end
    take       = o_a_ready | o_b_ready;
    timeout    = (state_reg == S_ARB) && (mode_reg != MODE_MUTE) && !take &&
                 (timer_reg == '0);
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (frame_edge) state_next = S_ARB;
      S_ARB:   if ((mode_reg == MODE_MUTE) || take || timeout) state_next = S_PUSH;
      S_PUSH:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_req_reg  <= 1'b0;
      mode_reg       <= MODE_MUTE;
      timer_reg      <= '0;
      latch_reg      <= '0;
      latch_src_reg  <= SRC_NONE;
      o_left         <= '0;
      o_right        <= '0;
      o_sample_valid <= 1'b0;
      o_active_src   <= 2'b00;
      o_underrun     <= 1'b0;
    end else begin
      frame_req_reg  <= i_frame_req;
      o_sample_valid <= 1'b0;
      o_underrun     <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (frame_edge) begin
            mode_reg  <= mode_e'(i_mode);
            timer_reg <= TMR_W'(TIMEOUT - 1);
          end
        end
        S_ARB: begin
          if (mode_reg == MODE_MUTE) begin
            latch_reg     <= '0;
            latch_src_reg <= SRC_NONE;
          end else if (o_a_ready) begin
            latch_reg     <= '{left: i_a_left, right: i_a_right};
            latch_src_reg <= SRC_A;
          end else if (o_b_ready) begin
            latch_reg     <= '{left: i_b_left, right: i_b_right};
            latch_src_reg <= SRC_B;
          end else if (timeout) begin
            // Holding leaves latch_reg at the last pushed pair.
            o_underrun    <= 1'b1;
            latch_src_reg <= SRC_NONE;
            if (!HOLD_ON_UNDERRUN) latch_reg <= '0;
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end
        S_PUSH: begin
          o_sample_valid <= 1'b1;
          o_left         <= latch_reg.left;
          o_right        <= latch_reg.right;
          o_active_src   <= latch_src_reg;
        end
        default: ;
      endcase
    end
  end

  mod_sat_counter #(.CNT_W(CNT_W)) u_underrun_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (timeout),
    .o_count (o_underrun_cnt)
  );

  mod_sat_counter #(.CNT_W(CNT_W)) u_overrun_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (overrun_inc),
    .o_count (o_overrun_cnt)
  );

endmodule

// File: tb/tb_mod_i2s_src_arb.sv
// Directed bench for the I2S source arbiter: reset, modes, priority, underrun
// saturation, overrun and mid-frame mode change.
module tb_mod_i2s_src_arb;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_frame_req;
  logic [1:0]  i_mode;
  logic        i_a_valid;
  logic [15:0] i_a_left, i_a_right;
  logic        o_a_ready;
  logic        i_b_valid;
  logic [15:0] i_b_left, i_b_right;
  logic        o_b_ready;
  logic [15:0] o_left, o_right;
  logic        o_sample_valid;
  logic [1:0]  o_active_src;
  logic        o_underrun;
  logic [7:0]  o_underrun_cnt, o_overrun_cnt;

  int checks = 0;
  int failures = 0;
  int sv_cnt = 0, a_rdy_cnt = 0, b_rdy_cnt = 0, both_rdy_cnt = 0, unr_cnt = 0;

  mod_i2s_src_arb dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_frame_req(i_frame_req), .i_mode(i_mode),
    .i_a_valid(i_a_valid), .i_a_left(i_a_left), .i_a_right(i_a_right), .o_a_ready(o_a_ready),
    .i_b_valid(i_b_valid), .i_b_left(i_b_left), .i_b_right(i_b_right), .o_b_ready(o_b_ready),
    .o_left(o_left), .o_right(o_right), .o_sample_valid(o_sample_valid),
    .o_active_src(o_active_src), .o_underrun(o_underrun),
    .o_underrun_cnt(o_underrun_cnt), .o_overrun_cnt(o_overrun_cnt)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_sample_valid) sv_cnt++;
    if (o_a_ready) a_rdy_cnt++;
    if (o_b_ready) b_rdy_cnt++;
    if (o_a_ready && o_b_ready) both_rdy_cnt++;
    if (o_underrun) unr_cnt++;
  end

  // Drop the request for one clock, then raise it to create a fresh edge.
  task automatic start_frame();
    i_frame_req = 1'b0;
    @(negedge i_clk);
    i_frame_req = 1'b1;
  endtask

  task automatic wait_valid(input int max, output int cyc, output bit found);
    cyc = 0;
    found = 1'b0;
    while (!found && cyc < max) begin
      @(negedge i_clk);
      cyc++;
      if (o_sample_valid) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    int cyc; bit found;
    @(negedge i_clk);
    i_rst_n = 1'b1; i_mode = 2'b01; i_a_valid = 1'b0; i_frame_req = 1'b1;
    @(negedge i_clk);
    i_a_valid = 1'b1; i_a_left = 16'h5A5A; i_a_right = 16'hA5A5;
    #1;
    checks++;
    if (o_a_ready !== 1'b1) begin
      failures++; $display("FAIL ready_before_reset got=%b want=1", o_a_ready);
    end
    #1 i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_a_ready, o_b_ready, o_left, o_right, o_sample_valid, o_active_src,
         o_underrun, o_underrun_cnt, o_overrun_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got ready=%b left=%h right=%h sv=%b src=%b unr=%0d ovr=%0d want=all 0",
               o_a_ready, o_left, o_right, o_sample_valid, o_active_src, o_underrun_cnt, o_overrun_cnt);
    end
    @(negedge i_clk);
    i_frame_req = 1'b0; i_a_valid = 1'b0; i_rst_n = 1'b1;
    sv_cnt = 0;
    repeat (4) @(negedge i_clk);
    checks++;
    if (sv_cnt !== 0 || o_left !== 16'h0000) begin
      failures++; $display("FAIL no_partial_transfer got sv=%0d left=%h want=0 0000", sv_cnt, o_left);
    end
    i_mode = 2'b00;
    start_frame();
    wait_valid(10, cyc, found);
    checks++;
    if (!found || cyc !== 3 || o_left !== 16'h0 || o_right !== 16'h0 || o_active_src !== 2'b00) begin
      failures++;
      $display("FAIL mute_after_reset got found=%b lat=%0d l=%h r=%h src=%b want=1 3 0000 0000 00",
               found, cyc, o_left, o_right, o_active_src);
    end
    $display("reset/mute frame: lat=%0d left=%h right=%h src=%b", cyc, o_left, o_right, o_active_src);
  endtask

  task automatic test_mode_a();
    int cyc; bit found;
    i_mode = 2'b01; i_a_valid = 1'b1; i_a_left = 16'h1234; i_a_right = 16'hABCD; i_b_valid = 1'b0;
    a_rdy_cnt = 0; b_rdy_cnt = 0;
    start_frame();
    wait_valid(10, cyc, found);
    checks++;
    if (!found || cyc !== 3) begin
      failures++; $display("FAIL mode_a_latency got found=%b lat=%0d want=1 3", found, cyc);
    end
    checks++;
    if (o_left !== 16'h1234 || o_right !== 16'hABCD || o_active_src !== 2'b01) begin
      failures++; $display("FAIL mode_a_data got l=%h r=%h src=%b want=1234 abcd 01", o_left, o_right, o_active_src);
    end
    checks++;
    if (a_rdy_cnt !== 1 || b_rdy_cnt !== 0) begin
      failures++; $display("FAIL mode_a_ready got a=%0d b=%0d want=1 0", a_rdy_cnt, b_rdy_cnt);
    end
    $display("mode A frame: lat=%0d left=%h right=%h src=%b", cyc, o_left, o_right, o_active_src);
  endtask

  task automatic test_bpri();
    int cyc; bit found;
    i_mode = 2'b11; i_a_valid = 1'b1; i_b_valid = 1'b1; i_b_left = 16'h0F0F; i_b_right = 16'hF0F0;
    a_rdy_cnt = 0; b_rdy_cnt = 0;
    start_frame();
    wait_valid(10, cyc, found);
    checks++;
    if (!found || o_left !== 16'h0F0F || o_right !== 16'hF0F0 || o_active_src !== 2'b10) begin
      failures++; $display("FAIL bpri_both got found=%b l=%h r=%h src=%b want=1 0f0f f0f0 10",
                           found, o_left, o_right, o_active_src);
    end
    checks++;
    if (a_rdy_cnt !== 0 || b_rdy_cnt !== 1) begin
      failures++; $display("FAIL bpri_ready got a=%0d b=%0d want=0 1", a_rdy_cnt, b_rdy_cnt);
    end
    $display("B-priority both valid: left=%h src=%b", o_left, o_active_src);
    i_b_valid = 1'b0;
    a_rdy_cnt = 0;
    start_frame();
    wait_valid(10, cyc, found);
    checks++;
    if (!found || o_left !== 16'h1234 || o_right !== 16'hABCD || o_active_src !== 2'b01 || a_rdy_cnt !== 1) begin
      failures++; $display("FAIL bpri_fallback got found=%b l=%h src=%b a_rdy=%0d want=1 1234 01 1",
                           found, o_left, o_active_src, a_rdy_cnt);
    end
    $display("B-priority B idle: left=%h src=%b", o_left, o_active_src);
  endtask

  task automatic test_underrun();
    int cyc; bit found;
    i_mode = 2'b10; i_a_valid = 1'b0; i_b_valid = 1'b0;
    unr_cnt = 0;
    start_frame();
    cyc = 0;
    while (!o_underrun && cyc < 100) begin
      @(negedge i_clk);
      cyc++;
    end
    checks++;
    if (cyc !== 65 || o_underrun_cnt !== 8'd1) begin
      failures++; $display("FAIL underrun_timing got cyc=%0d cnt=%0d want=65 1", cyc, o_underrun_cnt);
    end
    @(negedge i_clk);
    checks++;
    if (o_sample_valid !== 1'b1 || o_left !== 16'h1234 || o_right !== 16'hABCD || o_active_src !== 2'b00) begin
      failures++; $display("FAIL underrun_hold got sv=%b l=%h r=%h src=%b want=1 1234 abcd 00",
                           o_sample_valid, o_left, o_right, o_active_src);
    end
    @(negedge i_clk);
    checks++;
    if (unr_cnt !== 1) begin
      failures++; $display("FAIL underrun_pulse got pulses=%0d want=1", unr_cnt);
    end
    $display("underrun frame: cyc=%0d cnt=%0d left=%h", cyc, o_underrun_cnt, o_left);
    for (int i = 1; i < 300; i++) begin
      start_frame();
      wait_valid(100, cyc, found);
      if (!found) begin
        checks++; failures++;
        $display("FAIL underrun_loop got no sample_valid at frame %0d want=sample_valid", i);
        break;
      end
      if (i == 254) begin
        checks++;
        if (o_underrun_cnt !== 8'd255) begin
          failures++; $display("FAIL underrun_cnt_255 got=%0d want=255", o_underrun_cnt);
        end
      end
    end
    checks++;
    if (o_underrun_cnt !== 8'd255 || o_overrun_cnt !== 8'd0) begin
      failures++; $display("FAIL underrun_saturate got unr=%0d ovr=%0d want=255 0", o_underrun_cnt, o_overrun_cnt);
    end
    $display("after 300 underruns: cnt=%0d", o_underrun_cnt);
  endtask

  task automatic test_overrun_mode_change();
    int cyc, base; bit found;
    i_mode = 2'b01; i_a_valid = 1'b0; i_a_left = 16'h5555; i_a_right = 16'hAAAA;
    start_frame();
    @(negedge i_clk);
    i_frame_req = 1'b0; i_mode = 2'b10;
    @(negedge i_clk);
    i_frame_req = 1'b1;
    @(negedge i_clk);
    i_a_valid = 1'b1;
    base = sv_cnt;
    wait_valid(10, cyc, found);
    checks++;
    if (!found || o_left !== 16'h5555 || o_right !== 16'hAAAA || o_active_src !== 2'b01) begin
      failures++; $display("FAIL mode_change_frame got found=%b l=%h r=%h src=%b want=1 5555 aaaa 01",
                           found, o_left, o_right, o_active_src);
    end
    checks++;
    if (o_overrun_cnt !== 8'd1) begin
      failures++; $display("FAIL overrun_cnt got=%0d want=1", o_overrun_cnt);
    end
    repeat (6) @(negedge i_clk);
    checks++;
    if (sv_cnt - base !== 1) begin
      failures++; $display("FAIL overrun_dropped got pulses=%0d want=1", sv_cnt - base);
    end
    $display("overrun frame: left=%h src=%b ovr=%0d pulses=%0d", o_left, o_active_src, o_overrun_cnt, sv_cnt - base);
  endtask

  task automatic test_mute_after_data();
    int cyc; bit found;
    i_mode = 2'b00; i_a_valid = 1'b1; i_b_valid = 1'b1;
    a_rdy_cnt = 0; b_rdy_cnt = 0;
    start_frame();
    wait_valid(10, cyc, found);
    checks++;
    if (!found || cyc !== 3 || o_left !== 16'h0 || o_right !== 16'h0 || o_active_src !== 2'b00 ||
        a_rdy_cnt !== 0 || b_rdy_cnt !== 0) begin
      failures++; $display("FAIL mute_after_data got found=%b lat=%0d l=%h r=%h src=%b a=%0d b=%0d want=1 3 0000 0000 00 0 0",
                           found, cyc, o_left, o_right, o_active_src, a_rdy_cnt, b_rdy_cnt);
    end
    checks++;
    if (both_rdy_cnt !== 0) begin
      failures++; $display("FAIL single_ready got both=%0d want=0", both_rdy_cnt);
    end
    $display("mute frame after data: left=%h right=%h src=%b", o_left, o_right, o_active_src);
  endtask

  initial begin
    i_rst_n = 1'b0; i_frame_req = 1'b0; i_mode = 2'b00;
    i_a_valid = 1'b0; i_a_left = '0; i_a_right = '0;
    i_b_valid = 1'b0; i_b_left = '0; i_b_right = '0;
    repeat (3) @(negedge i_clk);
    test_reset();
    test_mode_a();
    test_bpri();
    test_underrun();
    test_overrun_mode_change();
    test_mute_after_data();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_i2s_src_arb.md
Name: mod_i2s_src_arb

Overview:
Controller that feeds stereo samples to the I2S transmitter once per frame, sharing it between two sample sources (A = playback stream, B = alert/tone source).
- On each frame request from the transmitter, it selects a source according to a mode setting and performs a valid/ready handshake with that source.
- It presents the latched left/right pair to the transmitter's serializer.
- It detects and counts underruns (source not ready in time) and frame overruns (a new request while still arbitrating).

Parameters:
SAMPLE_W, 16, bits per channel sample
TIMEOUT, 64, i_clk cycles allowed for a source to present valid after arbitration starts; must be less than the frame period (2048 cycles at the current divider)
HOLD_ON_UNDERRUN, 1, 1 = repeat last sample on underrun; 0 = output zero
CNT_W, 8, width of underrun/overrun counters (saturating)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_frame_req  in  1  transmitter ready level; rising edge = start of frame
i_mode  in  2  00 mute, 01 A only, 10 B only, 11 B priority over A
i_a_valid  in  1  source A sample valid
i_a_left  in  SAMPLE_W  source A left sample
i_a_right  in  SAMPLE_W  source A right sample
o_a_ready  out  1  source A sample accepted this cycle
i_b_valid  in  1  source B sample valid
i_b_left  in  SAMPLE_W  source B left sample
i_b_right  in  SAMPLE_W  source B right sample
o_b_ready  out  1  source B sample accepted this cycle
o_left  out  SAMPLE_W  current left sample to serializer
o_right  out  SAMPLE_W  current right sample to serializer
o_sample_valid  out  1  one-cycle pulse: o_left/o_right updated
o_active_src  out  2  00 none/mute, 01 A, 10 B (source of current sample)
o_underrun  out  1  one-cycle pulse on underrun
o_underrun_cnt  out  CNT_W  saturating underrun count
o_overrun_cnt  out  CNT_W  saturating overrun count

Behaviour:
- Reset (async assert, sync release): all outputs 0; state S_IDLE; edge-detect register 0.
- Frame edge: i_frame_req registered once; edge = i_frame_req & ~prev.
- Mode is sampled only on the S_IDLE→S_ARB transition and held for the whole frame. A mid-frame mode change has no effect until the next frame.

State machine:
- S_IDLE: on edge → S_ARB. Load the timeout counter with TIMEOUT-1 and latch the mode.
- S_ARB: select the source each cycle:
  - mode 01: A
  - mode 10: B
  - mode 11: B if i_b_valid, else A
  - mode 00: go straight to S_PUSH with zero samples and src=00, no handshake.
- Handshake in S_ARB:
  - o_x_ready = selected valid, combinational, asserted only in S_ARB. At most one ready is high per cycle.
  - Transfer on valid & ready: latch left/right and src, then → S_PUSH.
- Timeout: if the counter reaches 0 with no transfer, → S_PUSH as an underrun.
  - Samples: held (HOLD_ON_UNDERRUN=1) or zeroed.
  - o_active_src = 00.
  - o_underrun pulses for 1 cycle; o_underrun_cnt increments and saturates at all-ones.
- S_PUSH: drive o_sample_valid high for exactly 1 cycle, with o_left/o_right/o_active_src updated in the same cycle; → S_IDLE.
- Latency: with the source already valid, edge cycle +3 cycles to o_sample_valid (edge register, S_ARB transfer, S_PUSH).
- Overrun: an edge arriving while in S_ARB or S_PUSH increments o_overrun_cnt (saturating) and is otherwise dropped; no new frame starts.
- Simultaneous A and B valid in mode 11: B wins; A's ready stays 0.
- Async reset mid-handshake: ready drops immediately; no partial transfer is recorded.
- o_left/o_right hold their value between S_PUSH pulses.

Decomposition:
- Package i2s_pkg:
  - SAMPLE_W default constant
  - mode enum (MODE_MUTE, MODE_A, MODE_B, MODE_BPRI)
  - source enum (SRC_NONE, SRC_A, SRC_B)
  - state enum (S_IDLE, S_ARB, S_PUSH)
  - stereo sample struct {left, right}
- Sub-module: mod_sat_counter (CNT_W, increment, async active-low reset), instantiated twice for the underrun and overrun counts.

Test Plan:
- Reset: assert i_rst_n=0 mid-cycle → all outputs 0 immediately. Release, then drive a frame edge in mode 00 → o_sample_valid pulse with left=right=0, src=00.
- Mode 01 with A valid (L=0x1234, R=0xABCD) held → o_a_ready high 1 cycle, o_b_ready 0. Then o_sample_valid 3 cycles after the edge with o_left=0x1234, o_right=0xABCD, src=01.
- Mode 11 with A and B both valid (B L=0x0F0F) → only o_b_ready asserts, output 0x0F0F, src=10. Next frame with B invalid → A selected.
- Mode 10 with B never valid, TIMEOUT=64 → o_underrun pulses 64 cycles after entering S_ARB and the last sample repeats, src=00. Run 300 underruns with CNT_W=8 → counter saturates at 255.
- Second i_frame_req edge injected during S_ARB → o_overrun_cnt=1 and no extra o_sample_valid. Change i_mode from 01 to 10 mid-S_ARB → the current frame still completes from A.
